// File: rtl/div_unit.sv
// Iterative non-restoring divider: signed/unsigned, WIDTH+1 cycle latency, with a divide-by-zero flag.
// Define DIV_FAST_PATH_EN to skip the iteration when the quotient is trivially zero or the divisor is zero.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + WIDTH'(1)) : x;
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [WIDTH-1:0]        quo_q, quo_d;
  logic [WIDTH-1:0]        rem_q, rem_d;
  logic                    dbz_q, dbz_d;

  logic signed [WIDTH:0]   pr_q, pr_d;
  logic [WIDTH-1:0]        acc_q, acc_d;
  logic [WIDTH-1:0]        dvs_q, dvs_d;
  logic                    q_neg_q, q_neg_d;
  logic                    r_neg_q, r_neg_d;
  logic                    dbz_op_q, dbz_op_d;

  logic [WIDTH-1:0]        mag_dvd, mag_dvs;
  logic signed [WIDTH:0]   dvs_ext, pr_sh, pr_step;
  logic [WIDTH-1:0]        pr_fix;

  assign mag_dvd = cond_neg(dividend, is_signed & dividend[WIDTH-1]);
  assign mag_dvs = cond_neg(divisor,  is_signed & divisor[WIDTH-1]);

  // Partial remainder stays within [-D, D); the shifted value may wrap, but the
  // add/subtract result always fits, and the decision uses the pre-shift sign.
  assign dvs_ext = $signed({1'b0, dvs_q});
  assign pr_sh   = $signed({pr_q[WIDTH-1:0], acc_q[WIDTH-1]});
  assign pr_step = pr_q[WIDTH] ? (pr_sh + dvs_ext) : (pr_sh - dvs_ext);
  assign pr_fix  = pr_q[WIDTH] ? (pr_q[WIDTH-1:0] + dvs_q) : pr_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    pr_d     = pr_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dbz_op_d = dbz_op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_neg_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d  = is_signed & dividend[WIDTH-1];
          dbz_op_d = (divisor == '0);
          busy_d   = 1'b1;
          cnt_d    = '0;
          pr_d     = '0;
          acc_d    = mag_dvd;
          dvs_d    = mag_dvs;
          state_d  = CALC;
`ifdef DIV_FAST_PATH_EN
          // Quotient is zero and the remainder is the dividend magnitude.
          if ((divisor == '0) || (mag_dvd < mag_dvs)) begin
            pr_d    = $signed({1'b0, mag_dvd});
            acc_d   = '0;
            state_d = FIX;
          end
`endif
        end
      end
      CALC: begin
        pr_d  = pr_step;
        acc_d = {acc_q[WIDTH-2:0], ~pr_step[WIDTH]};
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        // Divide by zero leaves |dividend| in the partial remainder, so the
        // sign fix-up restores the original dividend.
        quo_d   = dbz_op_q ? '1 : cond_neg(acc_q, q_neg_q);
        rem_d   = cond_neg(pr_fix, r_neg_q);
        dbz_d   = dbz_op_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Datapath registers are always reloaded on capture, so they need no reset.
  always_ff @(negedge clk) begin
    pr_q     <= pr_d;
    acc_q    <= acc_d;
    dvs_q    <= dvs_d;
    q_neg_q  <= q_neg_d;
    r_neg_q  <= r_neg_d;
    dbz_op_q <= dbz_op_d;
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised iterative divider for the CPU datapath; successor to the fixed 32-bit unsigned divider.
- Supports signed and unsigned operation, selected per operation, at a configurable operand width.
- Uses non-restoring division with one final correction cycle, and provides a done pulse and a divide-by-zero flag.
- Sits beside the multiplier, serves DIV/DIVU, and writes HI/LO through the existing busy-stall interface.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH), width of the iteration counter; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the falling edge, matching the datapath's divider timing.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only while busy=0.
- is_signed  in  1  1 = two's-complement operation, 0 = unsigned; captured with start.
- dividend  in  WIDTH  numerator; captured with start.
- divisor  in  WIDTH  denominator; captured with start.
- quotient  out  WIDTH  registered quotient; held until the next completion.
- remainder  out  WIDTH  registered remainder; held until the next completion.
- busy  out  1  high from the capture edge until the result edge.
- done  out  1  one-cycle pulse on the result edge.
- div_by_zero  out  1  registered; valid from done, held with the results.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0. Reset asserted mid-operation aborts the operation immediately with the same values.
- States:
  - IDLE: start=1 captures the operands. When is_signed=1, it stores the magnitudes as WIDTH-bit unsigned values (|MIN| = 2^(WIDTH-1)), plus q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend). It also latches the divisor==0 condition, sets busy=1, clears counter and partial remainder, and moves to CALC.
  - CALC: one non-restoring step per edge. The WIDTH+1-bit partial remainder is shifted left with the next dividend bit. It is added to the divisor if its sign is negative, otherwise the divisor is subtracted. The quotient bit is the inverted new sign. After WIDTH steps (counter reaches WIDTH-1) the block moves to FIX.
  - FIX: if the partial remainder is negative, the divisor is added back. The quotient is negated if q_neg, and the remainder is negated if r_neg. quotient, remainder and div_by_zero are written. The block pulses done=1, sets busy=0 and returns to IDLE.
- Latency: the capture edge is E0 and the result edge is E(WIDTH+1). busy is high for exactly WIDTH+1 cycles, independent of operands.
- Start handling:
  - start while busy=1 is ignored; operand inputs are don't-care.
  - start on the same edge that done pulses is not accepted, because busy is still 1 before that edge. It is accepted on the following edge.
- Output stability: quotient and remainder change only on a FIX edge or on reset. They are never updated during CALC.
- Divide by zero: the operation runs the full latency. Results are quotient = all ones and remainder = the original dividend (signed or unsigned), with div_by_zero=1.
- Signed overflow: MIN / -1 gives quotient=MIN and remainder=0, with no flag.
- Remainder sign follows the dividend, and |remainder| < |divisor|.

Optional Feature:
- DIV_FAST_PATH_EN defined:
  - From IDLE, if divisor==0, or the unsigned magnitude of the dividend is less than the magnitude of the divisor, the block skips CALC and goes straight to FIX.
  - Results are identical to the normal path: quotient=0 and remainder=dividend, or the divide-by-zero values.
  - busy lasts 1 cycle and done comes on E1.
- DIV_FAST_PATH_EN undefined: fixed WIDTH+1-cycle latency for every operation.

Test Plan (WIDTH=32, DIV_FAST_PATH_EN undefined unless noted):
- Unsigned 100/7 -> quotient=14, remainder=2; done pulses exactly 33 edges after capture, and busy is high for 33 cycles.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0. Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Unsigned 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1 at done; the flag clears on the next completed non-zero divide.
- During a busy operation:
  - start with new operands at E10 is ignored, and the original results are delivered.
  - reset at E15 gives busy=0, quotient=0, and no done pulse.
  - A new start after reset completes correctly.
- With DIV_FAST_PATH_EN defined, unsigned 3/10 -> quotient=0, remainder=3, done at E1. Also, 100/7 still takes 33 cycles.
